// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a one-entry
// instruction holding register, and redirect handling that discards any
// in-flight fetch when control flow changes.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_base,
  input  logic [31:0] imm_ext
);

  typedef enum logic [1:0] {StReq, StWait, StFull, StDrop} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic        r_inst_valid, w_inst_valid_d;
  logic [31:0] r_instruction, w_instruction_d;
  logic [31:0] r_inst_pc, w_inst_pc_d;
  logic [31:0] w_target;
  logic [31:0] w_sum;

  // Redirect target: word-aligned sum, wrapping modulo 2^32.
  always_comb begin
    w_sum    = redirect_base + imm_ext;
    w_target = {w_sum[31:2], 2'b00};
  end

  // Next-state logic; a redirect overrides every other event in the cycle.
  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_inst_valid_d  = r_inst_valid;
    w_instruction_d = r_instruction;
    w_inst_pc_d     = r_inst_pc;
    unique case (r_state)
      StReq: begin
        if (redirect_valid) begin
          w_pc_d = w_target;
          // An accepted request must still have its response drained.
          if (imem_req_ready) w_state_d = StDrop;
        end else if (imem_req_ready) begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          w_pc_d    = w_target;
          w_state_d = imem_rsp_valid ? StReq : StDrop;
        end else if (imem_rsp_valid) begin
          w_instruction_d = imem_rsp_data;
          w_inst_pc_d     = r_pc;
          w_pc_d          = r_pc + 32'd4;
          w_inst_valid_d  = 1'b1;
          w_state_d       = StFull;
        end
      end
      StFull: begin
        if (redirect_valid) begin
          w_pc_d         = w_target;
          w_inst_valid_d = 1'b0;
          w_state_d      = StReq;
        end else if (inst_ready) begin
          w_inst_valid_d = 1'b0;
          w_state_d      = StReq;
        end
      end
      StDrop: begin
        if (redirect_valid) begin
          w_pc_d = w_target;
        end else if (imem_rsp_valid) begin
          w_state_d = StReq;
        end
      end
      default: w_state_d = StReq;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= StReq;
      r_pc          <= RESET_PC;
      r_inst_valid  <= 1'b0;
      r_instruction <= 32'h0;
      r_inst_pc     <= 32'h0;
    end else begin
      r_state       <= w_state_d;
      r_pc          <= w_pc_d;
      r_inst_valid  <= w_inst_valid_d;
      r_instruction <= w_instruction_d;
      r_inst_pc     <= w_inst_pc_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    imem_req_valid = (r_state == StReq);
    imem_addr      = r_pc;
    inst_valid     = r_inst_valid;
    instruction    = r_instruction;
    opcode         = r_instruction[6:0];
    inst_pc        = r_inst_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_base;
  logic [31:0] imm_ext;

  int n_cmp;
  int n_err;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .instruction    (instruction),
    .opcode         (opcode),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_base  (redirect_base),
    .imm_ext        (imm_ext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_base  = 32'h0;
    imm_ext        = 32'h0;
  endtask

  // Stimulus only: REQ -> WAIT -> FULL with the given word.
  task automatic fetch_to_full(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    redirect_valid = 1'b1;
    redirect_base  = 32'h1234;
    tick();
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: req_valid=%b addr=%h inst_valid=%b want 1/00000000/0",
               imem_req_valid, imem_addr, inst_valid);
    end
    n_cmp++;
    if (instruction !== 32'h0 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_regs: instruction=%h inst_pc=%h want 0/0", instruction, inst_pc);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold_req: req_valid=%b addr=%h want 1/00000000",
               imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_basic_fetch();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL basic_wait: req_valid=%b inst_valid=%b addr=%h want 0/0/00000000",
               imem_req_valid, inst_valid, imem_addr);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0013;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b1 || instruction !== 32'h13 || opcode !== 7'h13 || inst_pc !== 32'h0)
    begin
      n_err++;
      $display("FAIL basic_full: v=%b inst=%h op=%h pc=%h want 1/00000013/13/00000000",
               inst_valid, instruction, opcode, inst_pc);
    end
    n_cmp++;
    if (imem_req_valid !== 1'b0 || imem_addr !== 32'h4) begin
      n_err++;
      $display("FAIL basic_full_req: req_valid=%b addr=%h want 0/00000004",
               imem_req_valid, imem_addr);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin
      n_err++;
      $display("FAIL basic_next: inst_valid=%b req_valid=%b addr=%h want 0/1/00000004",
               inst_valid, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_stall();
    fetch_to_full(32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || instruction !== 32'h0050_0093 || opcode !== 7'h13 ||
          inst_pc !== 32'h4 || imem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: v=%b inst=%h op=%h pc=%h req=%b want 1/00500093/13/4/0",
                 i, inst_valid, instruction, opcode, inst_pc, imem_req_valid);
      end
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h8) begin
      n_err++;
      $display("FAIL stall_release: inst_valid=%b req_valid=%b addr=%h want 0/1/00000008",
               inst_valid, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_base  = 32'h100;
    imm_ext        = 32'hFFFF_FFF0;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || imem_addr !== 32'h0F0) begin
      n_err++;
      $display("FAIL redir_wait_drop: req_valid=%b addr=%h want 0/000000f0",
               imem_req_valid, imem_addr);
    end
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_wait_drop_hold: req_valid=%b want 0", imem_req_valid);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0F0 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_wait_after: req=%b addr=%h inst_valid=%b want 1/000000f0/0",
               imem_req_valid, imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_align();
    redirect_valid = 1'b1;
    redirect_base  = 32'h40;
    imm_ext        = 32'h6;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44) begin
      n_err++;
      $display("FAIL redir_align: req_valid=%b addr=%h want 1/00000044",
               imem_req_valid, imem_addr);
    end
    fetch_to_full(32'h0000_0063);
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h44 || opcode !== 7'h63) begin
      n_err++;
      $display("FAIL redir_align_fetch: v=%b pc=%h op=%h want 1/00000044/63",
               inst_valid, inst_pc, opcode);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_wait_rsp();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_base  = 32'h200;
    imm_ext        = 32'h8;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    tick();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h208 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_wait_rsp: req=%b addr=%h inst_valid=%b want 1/00000208/0",
               imem_req_valid, imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_req_and_drop();
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_base  = 32'h300;
    imm_ext        = 32'h0;
    tick();
    imem_req_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || imem_addr !== 32'h300) begin
      n_err++;
      $display("FAIL redir_req_ready: req_valid=%b addr=%h want 0/00000300",
               imem_req_valid, imem_addr);
    end
    // Second redirect while draining stays in the drain state.
    redirect_base = 32'h500;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || imem_addr !== 32'h500) begin
      n_err++;
      $display("FAIL redir_drop: req_valid=%b addr=%h want 0/00000500",
               imem_req_valid, imem_addr);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    tick();
    imem_rsp_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h500 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_done: req=%b addr=%h inst_valid=%b want 1/00000500/0",
               imem_req_valid, imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_full();
    fetch_to_full(32'h0000_0033);
    redirect_valid = 1'b1;
    redirect_base  = 32'h600;
    imm_ext        = 32'h10;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h610) begin
      n_err++;
      $display("FAIL redir_full: inst_valid=%b req=%b addr=%h want 0/1/00000610",
               inst_valid, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_base  = 32'hFFFF_FFF0;
    imm_ext        = 32'hC;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_target: addr=%h want fffffffc", imem_addr);
    end
    fetch_to_full(32'h0000_006F);
    n_cmp++;
    if (inst_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc: inst_pc=%h addr=%h want fffffffc/00000000", inst_pc, imem_addr);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_next: req_valid=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
    end
  endtask

  // Memory and downstream always ready: one instruction every 3 cycles.
  task automatic test_back_to_back();
    logic [31:0] base;
    base = 32'h800;
    redirect_valid = 1'b1;
    redirect_base  = base;
    imm_ext        = 32'h0;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0037;
    inst_ready     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_wait[%0d]: req=%b inst_valid=%b want 0/0", k, imem_req_valid, inst_valid);
      end
      tick();
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_pc !== base + 32'(4 * k) || opcode !== 7'h37) begin
        n_err++;
        $display("FAIL b2b_full[%0d]: v=%b pc=%h op=%h want 1/%h/37",
                 k, inst_valid, inst_pc, opcode, base + 32'(4 * k));
      end
      tick();
      n_cmp++;
      if (imem_req_valid !== 1'b1 || imem_addr !== base + 32'(4 * (k + 1))) begin
        n_err++;
        $display("FAIL b2b_req[%0d]: req=%b addr=%h want 1/%h",
                 k, imem_req_valid, imem_addr, base + 32'(4 * (k + 1)));
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_full();
    fetch_to_full(32'h0000_0017);
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_base  = 32'h700;
    imm_ext        = 32'h0;
    tick();
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0 ||
        instruction !== 32'h0 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_full: v=%b req=%b addr=%h inst=%h pc=%h want 0/1/0/0/0",
               inst_valid, imem_req_valid, imem_addr, instruction, inst_pc);
    end
    idle_inputs();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: req=%b addr=%h inst_valid=%b want 1/00000000/0",
               imem_req_valid, imem_addr, inst_valid);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    test_reset();
    test_basic_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_align();
    test_redirect_wait_rsp();
    test_redirect_req_and_drop();
    test_redirect_full();
    test_wrap();
    test_back_to_back();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 imem_req_valid  output  1  SHALL mean a fetch request is presented.
REQ-005 imem_req_ready  input  1  SHALL mean memory accepts the request this cycle.
REQ-006 imem_addr  output  32  SHALL be the fetch address; it equals pc.
REQ-007 imem_rsp_valid  input  1  SHALL mean imem_rsp_data is valid this cycle.
REQ-008 imem_rsp_data  input  32  SHALL be the returned instruction word.
REQ-009 inst_valid  output  1  SHALL mean instruction, opcode and inst_pc are valid for decode/immediate generation.
REQ-010 inst_ready  input  1  SHALL mean downstream consumes the instruction this cycle.
REQ-011 instruction  output  32  SHALL be the held instruction word.
REQ-012 opcode  output  7  SHALL equal instruction[6:0].
REQ-013 inst_pc  output  32  SHALL be the address the held instruction was fetched from.
REQ-014 redirect_valid  input  1  SHALL request a control-flow redirect.
REQ-015 redirect_base  input  32  SHALL be the PC of the redirecting branch.
REQ-016 imm_ext  input  32  SHALL be the sign-extended branch offset from the immediate generator.

Function
REQ-017 States SHALL be REQ, WAIT, FULL, DROP; at most one request outstanding.
REQ-018 REQ: imem_req_valid=1; on imem_req_ready -> WAIT with pc unchanged; imem_rsp_valid ignored.
REQ-019 WAIT: imem_req_valid=0; on imem_rsp_valid, capture imem_rsp_data into instruction and pc into inst_pc, pc <= pc+4, inst_valid <= 1, -> FULL.
REQ-020 FULL: imem_req_valid=0, inst_valid=1, outputs stable; on inst_ready, inst_valid <= 0, -> REQ.
REQ-021 DROP: imem_req_valid=0; on imem_rsp_valid, discard data, -> REQ.
REQ-022 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-023 Redirect target SHALL be (redirect_base + imm_ext) mod 2^32 with bits [1:0] forced to 0.
REQ-024 redirect_valid SHALL have priority over every other event in the same cycle; pc <= target.
REQ-025 Redirect in REQ without imem_req_ready: stay REQ, next request uses target.
REQ-026 Redirect in REQ with imem_req_ready: -> DROP (accepted request discarded).
REQ-027 Redirect in WAIT with imem_rsp_valid: response discarded, -> REQ; without imem_rsp_valid: -> DROP.
REQ-028 Redirect in FULL (including when inst_ready is high): inst_valid <= 0, held instruction discarded, -> REQ.
REQ-029 Redirect in DROP: pc <= target, stay DROP.
REQ-030 Fetch latency SHALL be one cycle from response to inst_valid; minimum 3 cycles per instruction with ready memory and downstream.

Reset
REQ-031 When rst_n=0 at a clock edge: state <= REQ, pc <= RESET_PC, inst_valid <= 0, instruction <= 0, inst_pc <= 0, regardless of state or redirect_valid.
REQ-032 Reset mid-operation SHALL abandon any outstanding request; the first cycle after reset release SHALL present imem_req_valid=1, imem_addr=RESET_PC.

Verification
REQ-033 Reset, req_ready=1, rsp 32'h0000_0013 one cycle later, inst_ready=1 -> inst_valid with instruction 32'h13, opcode 7'h13, inst_pc 0; next imem_addr 4.
REQ-034 Hold inst_ready=0 for 5 cycles in FULL -> inst_valid, instruction, inst_pc stable, no new request.
REQ-035 Redirect in WAIT (base 32'h100, imm_ext 32'hFFFF_FFF0), response 2 cycles later -> response discarded, next imem_addr 32'h0F0.
REQ-036 Redirect with imm_ext 32'h6, base 32'h40 -> target 32'h44.
REQ-037 pc 32'hFFFF_FFFC fetched -> next imem_addr 32'h0000_0000.
REQ-038 rst_n=0 while in FULL with redirect_valid=1 -> inst_valid 0, imem_addr RESET_PC next cycle.
